// File: rtl/fir_cfg_pkg.sv
// Shared configuration for the polyphase FIR interpolator: loader state encoding,
// coefficient-count derivation and address-width helper.
package fir_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } fir_state_e;

  // A symmetric filter of order ORD stores only half of its taps.
  function automatic int num_coeffs(input int ord);
    return (ord + 1) >> 1;
  endfunction

  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_coeff_loader_load_watchdog.sv
// load_watchdog: counts consecutive enabled cycles without a clear and flags the
// cycle on which the count would reach TIMEOUT.
module load_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th stalled cycle so the owner leaves LOAD on that edge.
  assign expired = en && !clr && (count_reg == TW'(TIMEOUT - 1));

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams a half-table of symmetric FIR coefficients into the
// interpolator write port. Optional checksum word: define FIR_COEFF_LOADER_CSUM_EN.
module fir_coeff_loader
  import fir_cfg_pkg::*;
#(
  parameter int ORD        = 255,
  parameter int COEFF_SIZE = 16,
  parameter int TIMEOUT    = 1024,
  localparam int NUM       = num_coeffs(ORD),
  localparam int AW        = addr_width(NUM)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [COEFF_SIZE-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  c_we,
  output logic [AW-1:0]         c_addr,
  output logic [COEFF_SIZE-1:0] c_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  fir_state_e state_reg, state_next;

  logic [AW-1:0]         cnt_reg, cnt_next;
  logic [AW-1:0]         c_addr_reg, c_addr_next;
  logic [COEFF_SIZE-1:0] c_in_reg, c_in_next;
  logic                  c_we_reg, c_we_next;
  logic                  s_ready_reg, busy_reg, done_reg, err_reg;

  logic hs, start_ok, last_word, wd_clr, wd_en, wd_expired;
  logic csum_phase, csum_match;

  assign hs        = s_valid & s_ready_reg;
  assign start_ok  = start && (state_reg inside {ST_IDLE, ST_DONE, ST_ERR});
  assign last_word = (cnt_reg == AW'(NUM - 1));

  // Timer restarts on every accepted word and whenever LOAD is (re)entered.
  assign wd_en  = (state_reg == ST_LOAD);
  assign wd_clr = (state_reg != ST_LOAD) || hs;

  load_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

`ifdef FIR_COEFF_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;

  logic                  csum_phase_reg;
  logic [COEFF_SIZE-1:0] sum_reg;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      csum_phase_reg <= 1'b0;
      sum_reg        <= '0;
    end else if (start_ok) begin
      csum_phase_reg <= 1'b0;
      sum_reg        <= '0;
    end else begin
      if (state_reg == ST_FLUSH) csum_phase_reg <= 1'b1;
      if (hs && !csum_phase_reg) sum_reg <= sum_reg + s_data;
    end
  end

  assign csum_phase = csum_phase_reg;
  assign csum_match = (s_data == sum_reg);
`else
  localparam bit CSUM_EN = 1'b0;

  assign csum_phase = 1'b0;
  assign csum_match = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    c_addr_next = c_addr_reg;
    c_in_next   = c_in_reg;
    c_we_next   = c_we_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: state_next = start ? ST_LOAD : ST_IDLE;
      ST_ERR:           if (start) state_next = ST_LOAD;
      ST_LOAD: begin
        if (wd_expired) begin
          state_next = ST_ERR;
        end else if (hs) begin
          if (csum_phase) begin
            state_next = csum_match ? ST_DONE : ST_ERR;
          end else begin
            c_in_next   = s_data;
            c_addr_next = cnt_reg;
            c_we_next   = 1'b1;
            cnt_next    = cnt_reg + 1'b1;
            if (last_word) state_next = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        c_we_next  = 1'b0;
        state_next = CSUM_EN ? ST_LOAD : ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (!(state_next inside {ST_LOAD, ST_FLUSH})) c_we_next = 1'b0;
    if (start_ok) cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      c_addr_reg  <= '0;
      c_in_reg    <= '0;
      c_we_reg    <= 1'b0;
      s_ready_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      c_addr_reg  <= c_addr_next;
      c_in_reg    <= c_in_next;
      c_we_reg    <= c_we_next;
      s_ready_reg <= (state_next == ST_LOAD);
      busy_reg    <= (state_next inside {ST_LOAD, ST_FLUSH});
      done_reg    <= (state_next == ST_DONE);
      err_reg     <= (state_next == ST_ERR);
    end
  end

  assign s_ready = s_ready_reg;
  assign c_we    = c_we_reg;
  assign c_addr  = c_addr_reg;
  assign c_in    = c_in_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader (ORD=15 -> 8 words, TIMEOUT=16); honours
// FIR_COEFF_LOADER_CSUM_EN when it is defined for the build.
module tb_fir_coeff_loader;

  localparam int ORD = 15;
  localparam int CS  = 16;
  localparam int TO  = 16;
  localparam int NUM = 8;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [CS-1:0] s_data = '0;
  logic          s_ready, c_we, busy, done, err;
  logic [2:0]    c_addr;
  logic [CS-1:0] c_in;

  int vectors = 0;
  int miscompares = 0;

  // Downstream coefficient RAM as the filter would see it.
  logic [CS-1:0] tbl [NUM];
  logic          tbl_clr = 1'b0;

  fir_coeff_loader #(
    .ORD        (ORD),
    .COEFF_SIZE (CS),
    .TIMEOUT    (TO)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .start   (start),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_in    (c_in),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tbl_clr) begin
      for (int i = 0; i < NUM; i++) tbl[i] <= '0;
    end else if (c_we) begin
      tbl[c_addr] <= c_in;
    end
  end

  function automatic logic [CS-1:0] w(input int k);
    return CS'(16'h0101 * (k + 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [CS-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
  endtask

  task automatic clear_table();
    tbl_clr = 1'b1;
    tick();
    tbl_clr = 1'b0;
  endtask

  // Called in the FLUSH cycle; returns sampled in the DONE/ERR cycle.
  task automatic close_load(input logic [CS-1:0] csum);
`ifdef FIR_COEFF_LOADER_CSUM_EN
    s_valid = 1'b1;
    s_data  = csum;
    tick();
    tick();
    s_valid = 1'b0;
`else
    s_valid = 1'b0;
    s_data  = csum;
    tick();
`endif
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick();
    tick();
    vectors++;
    if ({s_ready, c_we, busy, done, err} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 00000", {s_ready, c_we, busy, done, err});
    end
    vectors++;
    if (c_addr !== 3'd0 || c_in !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_port got addr=%0d in=%h exp addr=0 in=0000", c_addr, c_in);
    end
    nrst = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_back_to_back();
    logic [CS-1:0] e;
    clear_table();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({s_ready, busy, c_we} !== 3'b110) begin
      miscompares++;
      $display("FAIL b2b_start got %b exp 110", {s_ready, busy, c_we});
    end
    for (int k = 0; k < NUM; k++) begin
      e = w(k);
      send_word(e);
      vectors++;
      if (c_we !== 1'b1 || c_addr !== 3'(k) || c_in !== e) begin
        miscompares++;
        $display("FAIL b2b_word%0d got we=%b addr=%0d in=%h exp we=1 addr=%0d in=%h",
                 k, c_we, c_addr, c_in, k, e);
      end
      vectors++;
      if (s_ready !== (k < NUM - 1) || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready%0d got ready=%b busy=%b exp ready=%b busy=1",
                 k, s_ready, busy, (k < NUM - 1));
      end
    end
    close_load(16'h2424);
    vectors++;
    if ({done, busy, c_we, s_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL b2b_done got %b exp 1000", {done, busy, c_we, s_ready});
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done_pulse got %b exp 0", done);
    end
    for (int k = 0; k < NUM; k++) begin
      vectors++;
      if (tbl[k] !== w(k)) begin
        miscompares++;
        $display("FAIL b2b_table%0d got %h exp %h", k, tbl[k], w(k));
      end
    end
    $display("back-to-back load of %0d words complete", NUM);
  endtask

  task automatic test_gapped();
    clear_table();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) send_word(w(k));
    s_valid = 1'b0;
    for (int g = 0; g < 5; g++) begin
      tick();
      vectors++;
      if (c_we !== 1'b1 || c_addr !== 3'd3 || c_in !== 16'h0404 || err !== 1'b0 || s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL gap_hold%0d got we=%b addr=%0d in=%h err=%b rdy=%b exp we=1 addr=3 in=0404 err=0 rdy=1",
                 g, c_we, c_addr, c_in, err, s_ready);
      end
    end
    for (int k = 4; k < NUM; k++) send_word(w(k));
    close_load(16'h2424);
    vectors++;
    if (done !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_done got done=%b err=%b exp done=1 err=0", done, err);
    end
    for (int k = 0; k < NUM; k++) begin
      vectors++;
      if (tbl[k] !== w(k)) begin
        miscompares++;
        $display("FAIL gap_table%0d got %h exp %h", k, tbl[k], w(k));
      end
    end
    tick();
    $display("gapped load complete");
  endtask

  task automatic test_stall();
    clear_table();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) send_word(CS'(16'hA000 + k));
    s_valid = 1'b0;
    for (int c = 0; c < TO - 1; c++) tick();
    vectors++;
    if (err !== 1'b0 || c_we !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_early got err=%b we=%b exp err=0 we=1", err, c_we);
    end
    tick();
    vectors++;
    if ({err, c_we, s_ready, busy} !== 4'b1000) begin
      miscompares++;
      $display("FAIL stall_timeout got %b exp 1000", {err, c_we, s_ready, busy});
    end
    for (int k = 0; k < NUM; k++) begin
      vectors++;
      if (tbl[k] !== ((k < 6) ? CS'(16'hA000 + k) : 16'h0000)) begin
        miscompares++;
        $display("FAIL stall_table%0d got %h exp %h", k, tbl[k],
                 (k < 6) ? CS'(16'hA000 + k) : 16'h0000);
      end
    end
    tick();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_sticky got %b exp 1", err);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({err, s_ready, busy, c_we} !== 4'b0110) begin
      miscompares++;
      $display("FAIL stall_restart got %b exp 0110", {err, s_ready, busy, c_we});
    end
    send_word(w(0));
    vectors++;
    if (c_addr !== 3'd0 || c_in !== w(0) || c_we !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_reload got addr=%0d in=%h we=%b exp addr=0 in=%h we=1",
               c_addr, c_in, c_we, w(0));
    end
    for (int k = 1; k < NUM; k++) send_word(w(k));
    close_load(16'h2424);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_reload_done got %b exp 1", done);
    end
    tick();
    $display("stall abort and reload complete");
  endtask

  task automatic test_reset_midload();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) send_word(w(k));
    nrst = 1'b0;
    tick();
    vectors++;
    if ({c_we, busy, err, s_ready} !== 4'b0000 || c_addr !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst got we/busy/err/rdy=%b addr=%0d exp 0000 addr=0",
               {c_we, busy, err, s_ready}, c_addr);
    end
    nrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (s_ready !== 1'b0 || c_we !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_idle%0d got rdy=%b we=%b exp rdy=0 we=0", c, s_ready, c_we);
      end
    end
    s_valid = 1'b0;
    $display("reset during load handled");
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) send_word(w(k));
    start = 1'b1;
    send_word(w(3));
    start = 1'b0;
    vectors++;
    if (c_addr !== 3'd3 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_in_load got addr=%0d busy=%b exp addr=3 busy=1", c_addr, busy);
    end
    for (int k = 4; k < NUM - 1; k++) send_word(w(k));
    start = 1'b1;
    send_word(w(NUM - 1));
    start = 1'b0;
    vectors++;
    if (c_addr !== 3'd7 || busy !== 1'b1 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_last got addr=%0d busy=%b rdy=%b exp addr=7 busy=1 rdy=0",
               c_addr, busy, s_ready);
    end
    close_load(16'h2424);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL start_done got %b exp 1", done);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_no_restart got busy=%b rdy=%b exp 0 0", busy, s_ready);
    end
    $display("start during load ignored");
  endtask

  task automatic test_idle_valid();
    s_valid = 1'b1;
    s_data  = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({c_we, s_ready, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL idle_valid%0d got %b exp 000", c, {c_we, s_ready, busy});
      end
    end
    s_valid = 1'b0;
    $display("valid in idle ignored");
  endtask

`ifdef FIR_COEFF_LOADER_CSUM_EN
  task automatic test_csum_bad();
    clear_table();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NUM; k++) send_word(w(k));
    s_data  = 16'h2425;
    s_valid = 1'b1;
    tick();
    vectors++;
    if ({c_we, s_ready, busy} !== 3'b011 || c_addr !== 3'd7) begin
      miscompares++;
      $display("FAIL csum_wait got we/rdy/busy=%b addr=%0d exp 011 addr=7",
               {c_we, s_ready, busy}, c_addr);
    end
    tick();
    s_valid = 1'b0;
    vectors++;
    if ({err, done, c_we, s_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL csum_bad got %b exp 1000", {err, done, c_we, s_ready});
    end
    for (int k = 0; k < NUM; k++) begin
      vectors++;
      if (tbl[k] !== w(k)) begin
        miscompares++;
        $display("FAIL csum_table%0d got %h exp %h", k, tbl[k], w(k));
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL csum_err_clear got %b exp 0", err);
    end
    $display("checksum mismatch load complete");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_stall();
    test_reset_midload();
    test_start_ignored();
    test_idle_valid();
`ifdef FIR_COEFF_LOADER_CSUM_EN
    test_csum_bad();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
